// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the standard-to-pipelined Wishbone bridge.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Slave-response limit in cycles used when the instantiation does not override it
  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wb_bridge_timer.sv
// Slave-response timer: counts busy cycles since the request was issued and
// flags the cycle in which the count would reach TIMEOUT.
module wb_bridge_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear wins over count so a new request always starts from zero
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is flagged one count early so the FSM leaves exactly TIMEOUT cycles after entering REQ
  assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_std2pipe_bridge.sv
// Bridges a standard-mode Wishbone master onto a pipelined-mode Wishbone slave,
// one transaction at a time, with optional slave-response timeout.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no request; waiting for m_cyc & m_stb
// REQ     | s_cyc/s_stb asserted with the latched request until accepted
// WAIT    | request accepted (s_stb low), waiting for s_ack / s_err
// RESP    | one-cycle m_ack or m_err pulse back to the master
module wb_std2pipe_bridge
  import wb_bridge_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  // standard-mode master side
  input  logic            m_cyc,
  input  logic            m_stb,
  input  logic            m_we,
  input  logic [AW-1:0]   m_adr,
  input  logic [DW/8-1:0] m_sel,
  input  logic [DW-1:0]   m_dat_i,
  output logic            m_ack,
  output logic            m_err,
  output logic [DW-1:0]   m_dat_o,
  // pipelined-mode slave side
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW/8-1:0] s_sel,
  output logic [DW-1:0]   s_dat_o,
  input  logic            s_stall,
  input  logic            s_ack,
  input  logic            s_err,
  input  logic [DW-1:0]   s_dat_i
);

  state_e          state_q;
  logic            m_ack_q;
  logic            m_err_q;
  logic            s_cyc_q;
  logic            s_stb_q;
  logic            we_q;
  logic [AW-1:0]   adr_q;
  logic [DW/8-1:0] sel_q;
  logic [DW-1:0]   wdat_q;
  logic [DW-1:0]   rdat_q;

  logic to_clear;
  logic to_en;
  logic to_expired;

  assign to_clear = (state_q == ST_IDLE) && m_cyc && m_stb;
  assign to_en    = (state_q == ST_REQ) || (state_q == ST_WAIT);

  if (TIMEOUT > 0) begin : g_timer
    wb_bridge_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (to_clear),
      .enable_i  (to_en),
      .expired_o (to_expired)
    );
  end else begin : g_no_timer
    assign to_expired = 1'b0;
  end

  // Transaction sequencing; abort beats slave response, which beats timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      m_ack_q <= 1'b0;
      m_err_q <= 1'b0;
      s_cyc_q <= 1'b0;
      s_stb_q <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
    end else begin
      m_ack_q <= 1'b0;
      m_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (m_cyc && m_stb) begin
            we_q    <= m_we;
            adr_q   <= m_adr;
            sel_q   <= m_sel;
            wdat_q  <= m_dat_i;
            s_cyc_q <= 1'b1;
            s_stb_q <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!m_cyc) begin
            s_cyc_q <= 1'b0;
            s_stb_q <= 1'b0;
            state_q <= ST_IDLE;
          end else if (!s_stall && (s_ack || s_err)) begin
            rdat_q  <= s_dat_i;
            m_ack_q <= s_ack;
            m_err_q <= !s_ack;
            s_cyc_q <= 1'b0;
            s_stb_q <= 1'b0;
            state_q <= ST_RESP;
          end else if (to_expired) begin
            m_err_q <= 1'b1;
            s_cyc_q <= 1'b0;
            s_stb_q <= 1'b0;
            state_q <= ST_RESP;
          end else if (!s_stall) begin
            s_stb_q <= 1'b0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!m_cyc) begin
            s_cyc_q <= 1'b0;
            state_q <= ST_IDLE;
          end else if (s_ack || s_err) begin
            rdat_q  <= s_dat_i;
            m_ack_q <= s_ack;
            m_err_q <= !s_ack;
            s_cyc_q <= 1'b0;
            state_q <= ST_RESP;
          end else if (to_expired) begin
            m_err_q <= 1'b1;
            s_cyc_q <= 1'b0;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          s_cyc_q <= 1'b0;
          s_stb_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_ack   = m_ack_q;
  assign m_err   = m_err_q;
  assign m_dat_o = rdat_q;
  assign s_cyc   = s_cyc_q;
  assign s_stb   = s_stb_q;
  assign s_we    = we_q;
  assign s_adr   = adr_q;
  assign s_sel   = sel_q;
  assign s_dat_o = wdat_q;

endmodule
